oven_cook_ctrl: RTL and testbench
=================================

# oven_cook_ctrl

Parametrised successor to the oven front-end controller. It takes power-switch and push-key/step-switch entry for the target temperature and cook time. It sequences the oven through preheat, timed cook and done, with a heat request that includes hysteresis and a one-second countdown. It sits between the board inputs (keys, switches, temperature model) and the seven-segment display and heater logic.

## Interface
- TEMP_W, 10, width of temperature values
- TIME_W, 12, width of time values (seconds)
- TEMP_MIN, 65, lowest settable temperature
- TEMP_MAX, 500, highest settable temperature
- TEMP_DEFAULT, 300, target temperature loaded on power-up entry
- TIME_MAX, 1800, longest settable cook time
- HYST, 5, cook-phase heat hysteresis in degrees
- TICK_DIV, 50000000, clk cycles per one-second tick
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pwr  in  1  oven power switch (level, synchronous)
- key_inc_n  in  1  increment key, active-low, asynchronous pin
- key_dec_n  in  1  decrement key, active-low, asynchronous pin
- step_sel  in  5  one-hot step select switches
- cur_temp  in  TEMP_W  measured oven temperature
- target_temp  out  TEMP_W  current temperature setpoint
- target_time  out  TIME_W  programmed cook time
- remaining_time  out  TIME_W  cook seconds left
- state  out  3  FSM state code
- heat  out  1  heater request
- preheated  out  1  set once target reached, held until OFF
- done  out  1  one-cycle pulse when cook time expires

## Operation
- Keys use a two-flop synchroniser, reset to 1 (released). A press is a falling edge of the synchronised key.
- An inc press counts only if the synchronised dec key is high, and the reverse.
- Confirm occurs when both synchronised keys are low in the same cycle. After a confirm, both keys must be seen high before any press or confirm is accepted again (re-arm flag).
- Temperature step for step_sel bits 0..4 is 5/10/25/50/100. Time step for bits 0..4 is 5/10/30/60/300. A step_sel value that is not one-hot gives a step of 0.
- Arithmetic is done at width+1 and saturates. Temperature clamps to TEMP_MIN..TEMP_MAX. Time clamps to 0..TIME_MAX.
- States and codes:
  - OFF (0): target_temp=TEMP_DEFAULT, target_time=0, remaining_time=0, heat=0, preheated=0. pwr=1 moves to SET_TEMP.
  - SET_TEMP (1): inc/dec presses adjust target_temp. Confirm moves to SET_TIME.
  - SET_TIME (2): inc/dec presses adjust target_time. Confirm moves to PREHEAT only if target_time>0; otherwise confirm is consumed and ignored.
  - PREHEAT (3): heat = cur_temp < target_temp. When cur_temp >= target_temp, set preheated, load remaining_time=target_time, clear the tick counter, move to COOK.
  - COOK (4): heat=1 when cur_temp < target_temp-HYST, heat=0 when cur_temp >= target_temp, otherwise unchanged. Each tick decrements remaining_time. When it decrements to 0, pulse done, force heat=0, move to DONE.
  - DONE (5): heat=0. Confirm moves to SET_TEMP with target_temp and target_time kept.
- pwr=0 in any state moves to OFF on the next edge. This overrides every other event that cycle.

## Timing
- Reset: state=OFF, target_temp=TEMP_DEFAULT, target_time=0, remaining_time=0, heat=0, preheated=0, done=0, tick counter=0, synchronisers=1, re-arm flag=1.
- Key latency: the pin is sampled low at edge 1, and target_temp/target_time update at edge 3. Confirm uses the same latency.
- The tick counter runs only in COOK. The first decrement lands TICK_DIV cycles after entering COOK.
- The PREHEAT to COOK transition takes one cycle. heat in PREHEAT is registered, one cycle behind cur_temp.
- done is high for exactly the one cycle after remaining_time reaches 0, and only in that cycle.
- Simultaneous press and confirm in the same cycle: confirm wins and no adjustment is made.

## Configuration
- OVEN_CTRL_COOK_ADJUST_EN defined:
  - In COOK, inc/dec presses change remaining_time by the time step.
  - Increments saturate at TIME_MAX.
  - Decrements saturate at 1 and never end the cook directly.
  - A press and a tick in the same cycle apply both, press first.
- Not defined: keys are ignored in COOK and remaining_time changes only on ticks.

## Test plan
- Reset low mid-COOK -> all outputs return to reset values asynchronously; state=0.
- pwr=1, step_sel=5'b00100, three inc presses -> target_temp 300→325→350→375; a further step_sel=5'b10000 inc ×2 -> 475 then 500 (saturated).
- SET_TEMP, step_sel=5'b10000, four dec presses from 300 -> 200, 100, 65, 65; step_sel=5'b00011 inc -> unchanged.
- Confirm into SET_TIME with target_time=0, confirm again -> stays in state 2; step_sel=5'b00001 inc, release, confirm -> state 3.
- TICK_DIV=4, target_time=5, cur_temp ramped past target_temp -> preheated=1, COOK for 20 cycles, done pulses once, state=5, heat=0.
- OVEN_CTRL_COOK_ADJUST_EN defined, COOK with remaining_time=10, step_sel=5'b00010, dec twice -> 1 then 1; pwr=0 -> OFF next edge.

Source files
------------

// File: rtl/oven_cook_ctrl.sv
// oven_cook_ctrl: oven front-end sequencer for key entry, preheat, timed cook and done.
// Optional build macro OVEN_CTRL_COOK_ADJUST_EN: inc/dec keys edit remaining time in COOK.
module oven_cook_ctrl #(
  parameter int TEMP_W       = 10,
  parameter int TIME_W       = 12,
  parameter int TEMP_MIN     = 65,
  parameter int TEMP_MAX     = 500,
  parameter int TEMP_DEFAULT = 300,
  parameter int TIME_MAX     = 1800,
  parameter int HYST         = 5,
  parameter int TICK_DIV     = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwr,
  input  logic              key_inc_n,
  input  logic              key_dec_n,
  input  logic [4:0]        step_sel,
  input  logic [TEMP_W-1:0] cur_temp,
  output logic [TEMP_W-1:0] target_temp,
  output logic [TIME_W-1:0] target_time,
  output logic [TIME_W-1:0] remaining_time,
  output logic [2:0]        state,
  output logic              heat,
  output logic              preheated,
  output logic              done
);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_SET_TEMP = 3'd1,
    S_SET_TIME = 3'd2,
    S_PREHEAT  = 3'd3,
    S_COOK     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [TEMP_W:0]   T_MIN  = (TEMP_W+1)'(TEMP_MIN);
  localparam logic [TEMP_W:0]   T_MAX  = (TEMP_W+1)'(TEMP_MAX);
  localparam logic [TEMP_W:0]   T_HYST = (TEMP_W+1)'(HYST);
  localparam logic [TEMP_W-1:0] T_DEF  = TEMP_W'(TEMP_DEFAULT);
  localparam logic [TIME_W:0]   M_MAX  = (TIME_W+1)'(TIME_MAX);

  state_t st, nxt_st;

  logic [2:0] inc_sr, dec_sr;
  logic       armed;
  logic [CNT_W-1:0] cnt, nxt_cnt;

  logic [TEMP_W-1:0] nxt_temp;
  logic [TIME_W-1:0] nxt_time, nxt_rem;
  logic nxt_heat, nxt_pre, nxt_done;

  logic inc_s, dec_s, inc_fall, dec_fall;
  logic confirm, inc_press, dec_press, tick;

  logic [TEMP_W-1:0] t_step, t_up, t_dn;
  logic [TIME_W-1:0] m_step, m_up, m_dn, rem_adj;
  logic [TEMP_W:0]   t_sum, t_dif;
  logic [TIME_W:0]   m_sum, m_dif;
  logic cur_hot, cur_low;

  assign state = st;

  // key synchronisers; bit 2 is the previous synchronised value for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_sr <= 3'b111;
      dec_sr <= 3'b111;
    end else begin
      inc_sr <= {inc_sr[1:0], key_inc_n};
      dec_sr <= {dec_sr[1:0], key_dec_n};
    end
  end

  assign inc_s    = inc_sr[1];
  assign dec_s    = dec_sr[1];
  assign inc_fall = inc_sr[2] & ~inc_s;
  assign dec_fall = dec_sr[2] & ~dec_s;
  assign confirm   = armed & ~inc_s & ~dec_s;
  assign inc_press = armed & inc_fall & dec_s;
  assign dec_press = armed & dec_fall & inc_s;
  assign tick      = (cnt == CNT_LAST);

  // re-arm: after a confirm both keys must be released before new input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      armed <= 1'b1;
    else if (confirm)
      armed <= 1'b0;
    else if (inc_s && dec_s)
      armed <= 1'b1;
  end

  // step size decode; anything not one-hot gives zero
  always_comb begin
    t_step = '0;
    m_step = '0;
    case (step_sel)
      5'b00001: begin t_step = TEMP_W'(5);   m_step = TIME_W'(5);   end
      5'b00010: begin t_step = TEMP_W'(10);  m_step = TIME_W'(10);  end
      5'b00100: begin t_step = TEMP_W'(25);  m_step = TIME_W'(30);  end
      5'b01000: begin t_step = TEMP_W'(50);  m_step = TIME_W'(60);  end
      5'b10000: begin t_step = TEMP_W'(100); m_step = TIME_W'(300); end
      default: ;
    endcase
  end

  assign t_sum = {1'b0, target_temp} + {1'b0, t_step};
  assign t_dif = {1'b0, target_temp} - {1'b0, t_step};
  assign t_up  = (t_sum > T_MAX) ? T_MAX[TEMP_W-1:0] : t_sum[TEMP_W-1:0];
  assign t_dn  = (t_dif[TEMP_W] || t_dif < T_MIN) ?
                 T_MIN[TEMP_W-1:0] : t_dif[TEMP_W-1:0];

  assign m_sum = {1'b0, target_time} + {1'b0, m_step};
  assign m_dif = {1'b0, target_time} - {1'b0, m_step};
  assign m_up  = (m_sum > M_MAX) ? M_MAX[TIME_W-1:0] : m_sum[TIME_W-1:0];
  assign m_dn  = m_dif[TIME_W] ? '0 : m_dif[TIME_W-1:0];

`ifdef OVEN_CTRL_COOK_ADJUST_EN
  logic [TIME_W:0]   r_sum, r_dif;
  logic [TIME_W-1:0] r_up, r_dn;
  assign r_sum = {1'b0, remaining_time} + {1'b0, m_step};
  assign r_dif = {1'b0, remaining_time} - {1'b0, m_step};
  assign r_up  = (r_sum > M_MAX) ? M_MAX[TIME_W-1:0] : r_sum[TIME_W-1:0];
  // a key edit never ends the cook; only a tick can reach zero
  assign r_dn  = (r_dif[TIME_W] || r_dif == '0) ?
                 TIME_W'(1) : r_dif[TIME_W-1:0];
  assign rem_adj = inc_press ? r_up :
                   dec_press ? r_dn : remaining_time;
`else
  assign rem_adj = remaining_time;
`endif

  assign cur_hot = (cur_temp >= target_temp);
  assign cur_low = (({1'b0, cur_temp} + T_HYST) < {1'b0, target_temp});

  // next-state and next-output logic
  always_comb begin
    nxt_st   = st;
    nxt_temp = target_temp;
    nxt_time = target_time;
    nxt_rem  = remaining_time;
    nxt_heat = heat;
    nxt_pre  = preheated;
    nxt_done = 1'b0;
    nxt_cnt  = '0;
    if (!pwr) begin
      nxt_st   = S_OFF;
      nxt_temp = T_DEF;
      nxt_time = '0;
      nxt_rem  = '0;
      nxt_heat = 1'b0;
      nxt_pre  = 1'b0;
    end else begin
      unique case (st)
        S_OFF: begin
          nxt_temp = T_DEF;
          nxt_time = '0;
          nxt_rem  = '0;
          nxt_heat = 1'b0;
          nxt_pre  = 1'b0;
          nxt_st   = S_SET_TEMP;
        end
        S_SET_TEMP: begin
          if (confirm)
            nxt_st = S_SET_TIME;
          else if (inc_press)
            nxt_temp = t_up;
          else if (dec_press)
            nxt_temp = t_dn;
        end
        S_SET_TIME: begin
          if (confirm) begin
            if (target_time != '0)
              nxt_st = S_PREHEAT;
          end else if (inc_press) begin
            nxt_time = m_up;
          end else if (dec_press) begin
            nxt_time = m_dn;
          end
        end
        S_PREHEAT: begin
          nxt_heat = ~cur_hot;
          if (cur_hot) begin
            nxt_pre = 1'b1;
            nxt_rem = target_time;
            nxt_st  = S_COOK;
          end
        end
        S_COOK: begin
          nxt_rem = rem_adj;
          if (cur_low)
            nxt_heat = 1'b1;
          else if (cur_hot)
            nxt_heat = 1'b0;
          if (tick) begin
            nxt_rem = rem_adj - TIME_W'(1);
            if (rem_adj == TIME_W'(1)) begin
              nxt_done = 1'b1;
              nxt_heat = 1'b0;
              nxt_st   = S_DONE;
            end
          end else begin
            nxt_cnt = cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          nxt_heat = 1'b0;
          if (confirm)
            nxt_st = S_SET_TEMP;
        end
        default: nxt_st = S_OFF;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st             <= S_OFF;
      target_temp    <= T_DEF;
      target_time    <= '0;
      remaining_time <= '0;
      heat           <= 1'b0;
      preheated      <= 1'b0;
      done           <= 1'b0;
      cnt            <= '0;
    end else begin
      st             <= nxt_st;
      target_temp    <= nxt_temp;
      target_time    <= nxt_time;
      remaining_time <= nxt_rem;
      heat           <= nxt_heat;
      preheated      <= nxt_pre;
      done           <= nxt_done;
      cnt            <= nxt_cnt;
    end
  end

endmodule

// File: tb/tb_oven_cook_ctrl.sv
// tb_oven_cook_ctrl: directed + randomized checks of oven_cook_ctrl.
// Expected values come from a behavioural model of the entry/cook rules.
module tb_oven_cook_ctrl;

  localparam int TW = 10;
  localparam int MW = 12;
`ifdef OVEN_CTRL_COOK_ADJUST_EN
  localparam int ADJ = 1;
`else
  localparam int ADJ = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pwr = 1'b0;
  logic key_inc_n = 1'b1;
  logic key_dec_n = 1'b1;
  logic [4:0] step_sel = '0;
  logic [TW-1:0] cur_temp = TW'(20);
  logic [TW-1:0] target_temp;
  logic [MW-1:0] target_time;
  logic [MW-1:0] remaining_time;
  logic [2:0] state;
  logic heat, preheated, done;

  int tests = 0;
  int failed = 0;
  int et, em, mh;

  always #5 clk = ~clk;

  oven_cook_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pwr(pwr),
    .key_inc_n(key_inc_n),
    .key_dec_n(key_dec_n),
    .step_sel(step_sel),
    .cur_temp(cur_temp),
    .target_temp(target_temp),
    .target_time(target_time),
    .remaining_time(remaining_time),
    .state(state),
    .heat(heat),
    .preheated(preheated),
    .done(done)
  );

  function automatic int tstep(input int sel);
    case (sel)
      1: return 5;
      2: return 10;
      4: return 25;
      8: return 50;
      16: return 100;
      default: return 0;
    endcase
  endfunction

  function automatic int mstep(input int sel);
    case (sel)
      1: return 5;
      2: return 10;
      4: return 30;
      8: return 60;
      16: return 300;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic i_n, input logic d_n, input int n);
    key_inc_n = i_n;
    key_dec_n = d_n;
    repeat (n) step();
  endtask

  task automatic press(input bit inc);
    hold(inc ? 1'b0 : 1'b1, inc ? 1'b1 : 1'b0, 3);
    hold(1'b1, 1'b1, 3);
  endtask

  task automatic confirm();
    hold(1'b0, 1'b0, 3);
    hold(1'b1, 1'b1, 3);
  endtask

  task automatic temp_op(input bit inc, input logic [4:0] sel);
    step_sel = sel;
    press(inc);
    if (inc) et = (et + tstep(sel) > 500) ? 500 : et + tstep(sel);
    else     et = (et - tstep(sel) < 65) ? 65 : et - tstep(sel);
    chk("temp_op", 32'(target_temp), et);
  endtask

  task automatic time_op(input bit inc, input logic [4:0] sel);
    step_sel = sel;
    press(inc);
    if (inc) em = (em + mstep(sel) > 1800) ? 1800 : em + mstep(sel);
    else     em = (em - mstep(sel) < 0) ? 0 : em - mstep(sel);
    chk("time_op", 32'(target_time), em);
  endtask

  function automatic logic [4:0] rnd_sel();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'(1 << $urandom_range(0, 4));
  endfunction

  function automatic int sched(input int k);
    if (k <= 3) return 62;
    if (k <= 6) return 55;
    if (k <= 9) return 62;
    if (k <= 17) return 70;
    return 55;
  endfunction

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) step();
    chk("rst_state", 32'(state), 0);
    chk("rst_temp", 32'(target_temp), 300);
    chk("rst_time", 32'(target_time), 0);
    chk("rst_rem", 32'(remaining_time), 0);
    chk("rst_heat", 32'(heat), 0);
    chk("rst_pre", 32'(preheated), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    step();

    pwr = 1'b1;
    step();
    chk("pwr_on", 32'(state), 1);
    et = 300;
    em = 0;

    step_sel = 5'b00100;
    key_inc_n = 1'b0;
    step();
    step();
    chk("lat_edge2", 32'(target_temp), 300);
    step();
    et = 325;
    chk("lat_edge3", 32'(target_temp), et);
    hold(1'b1, 1'b1, 3);
    temp_op(1'b1, 5'b00100);
    temp_op(1'b1, 5'b00100);
    temp_op(1'b1, 5'b10000);
    temp_op(1'b1, 5'b10000);

    for (int i = 0; i < 16; i++)
      temp_op(1'($urandom_range(0, 1)), rnd_sel());

    pwr = 1'b0;
    step();
    chk("off_state", 32'(state), 0);
    chk("off_temp", 32'(target_temp), 300);
    pwr = 1'b1;
    step();
    chk("on_again", 32'(state), 1);
    et = 300;
    for (int i = 0; i < 4; i++) temp_op(1'b0, 5'b10000);
    temp_op(1'b1, 5'b00011);

    confirm();
    chk("to_set_time", 32'(state), 2);
    for (int i = 0; i < 16; i++)
      time_op(1'($urandom_range(0, 1)), rnd_sel());
    for (int i = 0; i < 7; i++) time_op(1'b0, 5'b10000);
    confirm();
    chk("zero_time_cfm", 32'(state), 2);
    time_op(1'b1, 5'b00001);

    cur_temp = TW'(20);
    confirm();
    chk("preheat_st", 32'(state), 3);
    chk("preheat_heat", 32'(heat), 1);
    chk("preheat_pre", 32'(preheated), 0);

    for (int c = 30; c <= 70; c += 10) begin
      cur_temp = TW'(c);
      step();
      if (c < et) begin
        chk("ramp_state", 32'(state), 3);
        chk("ramp_heat", 32'(heat), 1);
      end else begin
        chk("cook_entry", 32'(state), 4);
        chk("cook_pre", 32'(preheated), 1);
        chk("cook_rem", 32'(remaining_time), em);
        chk("cook_heat0", 32'(heat), 0);
      end
    end

    mh = 0;
    for (int k = 1; k <= 24; k++) begin
      cur_temp = TW'(sched(k));
      step();
      if (k < 20) begin
        if (sched(k) < et - 5) mh = 1;
        else if (sched(k) >= et) mh = 0;
        chk("cook_heat", 32'(heat), mh);
        chk("cook_cnt", 32'(remaining_time), em - k / 4);
        chk("cook_nodone", 32'(done), 0);
      end else if (k == 20) begin
        chk("done_pulse", 32'(done), 1);
        chk("done_state", 32'(state), 5);
        chk("done_heat", 32'(heat), 0);
        chk("done_rem", 32'(remaining_time), 0);
      end else begin
        chk("done_once", 32'(done), 0);
        chk("done_hold", 32'(state), 5);
        chk("done_heat_hold", 32'(heat), 0);
      end
    end

    confirm();
    chk("redo_state", 32'(state), 1);
    chk("redo_temp", 32'(target_temp), et);
    chk("redo_time", 32'(target_time), em);

    cur_temp = TW'(70);
    confirm();
    chk("a_set_time", 32'(state), 2);
    time_op(1'b1, 5'b00001);
    step_sel = 5'b00010;
    hold(1'b0, 1'b0, 3);
    chk("a_preheat", 32'(state), 3);
    hold(1'b1, 1'b1, 1);
    chk("a_cook", 32'(state), 4);
    chk("a_rem0", 32'(remaining_time), 10);
    key_dec_n = 1'b0;
    step();
    step();
    chk("a_rem2", 32'(remaining_time), 10);
    step();
    chk("a_rem3", 32'(remaining_time), ADJ != 0 ? 1 : 10);
    chk("a_state3", 32'(state), 4);
    key_dec_n = 1'b1;
    step();
    chk("a_rem4", 32'(remaining_time), ADJ != 0 ? 0 : 9);
    chk("a_done4", 32'(done), ADJ != 0 ? 1 : 0);
    chk("a_state4", 32'(state), ADJ != 0 ? 5 : 4);

    pwr = 1'b0;
    step();
    chk("pwr_off_st", 32'(state), 0);
    chk("pwr_off_rem", 32'(remaining_time), 0);
    chk("pwr_off_time", 32'(target_time), 0);
    chk("pwr_off_temp", 32'(target_temp), 300);
    chk("pwr_off_pre", 32'(preheated), 0);
    chk("pwr_off_heat", 32'(heat), 0);
    pwr = 1'b1;
    step();
    chk("b_on", 32'(state), 1);
    et = 300;
    em = 0;

    confirm();
    chk("b_set_time", 32'(state), 2);
    time_op(1'b1, 5'b00010);
    cur_temp = TW'(400);
    hold(1'b0, 1'b0, 3);
    chk("b_preheat", 32'(state), 3);
    hold(1'b1, 1'b1, 1);
    chk("b_cook", 32'(state), 4);
    step();
    key_inc_n = 1'b0;
    step();
    step();
    chk("b_rem3", 32'(remaining_time), 10);
    step();
    chk("b_rem4", 32'(remaining_time), ADJ != 0 ? 19 : 9);
    chk("b_heat", 32'(heat), 0);
    key_inc_n = 1'b1;

    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_temp", 32'(target_temp), 300);
    chk("arst_time", 32'(target_time), 0);
    chk("arst_rem", 32'(remaining_time), 0);
    chk("arst_heat", 32'(heat), 0);
    chk("arst_pre", 32'(preheated), 0);
    chk("arst_done", 32'(done), 0);
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
